vec_lane_sequencer: RTL

Multi-cycle sequencer for vector ALU instructions (VADD, VSUB, VAND, VORR, VXOR). It accepts an operation issued by the decoder and processes one lane per cycle through a single shared lane ALU. While busy it stalls the fetch/decode stage, then pulses a vector-register write with the assembled result. It sits between the decoder's `ALUControl`/`VecW` outputs and the vector register file, in parallel with the scalar ALU.

---
 rtl/vec_pkg.sv | 33 +++
 rtl/vec_lane_alu.sv | 29 ++
 rtl/vec_lane_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane sequencer: op codes, FSM states
// and default geometry.
package vec_pkg;

  // Default geometry: four 8-bit lanes form a 32-bit vector.
  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 8;

  // ALUControl codes the decoder uses for vector operations.
  localparam logic [3:0] OP_VADD = 4'b1000;
  localparam logic [3:0] OP_VSUB = 4'b1001;
  localparam logic [3:0] OP_VAND = 4'b1010;
  localparam logic [3:0] OP_VORR = 4'b1011;
  localparam logic [3:0] OP_VXOR = 4'b1111;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the five op codes the lane ALU implements.
  function automatic logic is_vec_op(input logic [3:0] op);
    logic ok;
    case (op)
      OP_VADD, OP_VSUB, OP_VAND, OP_VORR, OP_VXOR: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU shared by every lane of a vector op.
// Arithmetic wraps modulo 2^LANE_W; carries/borrows are simply dropped.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [3:0]        op,
  output logic [LANE_W-1:0] y,
  output logic              legal
);

  // Decode the op and compute one lane's result; unknown ops yield zero.
  always_comb begin
    y     = '0;
    legal = is_vec_op(op);
    case (op)
      OP_VADD: y = a + b;
      OP_VSUB: y = a - b;
      OP_VAND: y = a & b;
      OP_VORR: y = a | b;
      OP_VXOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Multi-cycle vector ALU sequencer: latches operands on Start, runs one
// lane per cycle through a shared lane ALU, then pulses Done/VecWE.
module vec_lane_sequencer
  import vec_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic [3:0]              ALUControl,
  input  logic [LANES*LANE_W-1:0] SrcA,
  input  logic [LANES*LANE_W-1:0] SrcB,
  output logic                    Stall,
  output logic                    Done,
  output logic                    VecWE,
  output logic [LANES*LANE_W-1:0] Result,
  output logic                    Zero,
  output logic                    Illegal
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   a_q, a_d;
  logic [VEC_W-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [VEC_W-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic [LANE_W-1:0]  lane_a, lane_b, alu_y;
  logic [3:0]         alu_op;
  logic               alu_legal;

  // Pick the current lane of the latched operands; in IDLE the ALU sees the
  // incoming op code so its legal flag can steer the issue decision.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        lane_a = a_q[i*LANE_W +: LANE_W];
        lane_b = b_q[i*LANE_W +: LANE_W];
      end
    end
    alu_op = (state_q == ST_IDLE) ? ALUControl : op_q;
  end

  vec_lane_alu #(
    .LANE_W (LANE_W)
  ) u_lane_alu (
    .a     (lane_a),
    .b     (lane_b),
    .op    (alu_op),
    .y     (alu_y),
    .legal (alu_legal)
  );

  // Next-state logic: issue, per-lane write-back, and completion flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d   = SrcA;
          b_d   = SrcB;
          op_d  = ALUControl;
          cnt_d = '0;
          if (alu_legal) begin
            state_d = ST_RUN;
          end else begin
            state_d   = ST_DONE;
            illegal_d = 1'b1;
            zero_d    = (result_q == '0);
          end
        end
      end
      ST_RUN: begin
        for (int i = 0; i < LANES; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            result_d[i*LANE_W +: LANE_W] = alu_y;
          end
        end
        if (cnt_q == CNT_W'(LANES - 1)) begin
          state_d   = ST_DONE;
          cnt_d     = '0;
          illegal_d = 1'b0;
          zero_d    = (result_d == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs; Stall is combinational from Start so the PC holds
  // in the issue cycle itself.
  always_comb begin
    Stall   = ((state_q == ST_IDLE) && Start) || (state_q == ST_RUN);
    Done    = (state_q == ST_DONE);
    VecWE   = (state_q == ST_DONE) && !illegal_q;
    Result  = result_q;
    Zero    = zero_q;
    Illegal = illegal_q;
  end

  // State register; reset discards any in-flight operation and its result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
